// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist_ctrl
// Brief    : LFSR write/readback self-test sequencer for a single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bist_ctrl #(
    parameter int          ADDR_W = 8,
    parameter int          RD_LAT = 1,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W:0]   o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_ena,
    output logic              o_wea,
    output logic [ADDR_W-1:0] o_addra,
    output logic [15:0]       o_dina,
    input  logic [15:0]       i_douta
);

    localparam logic [15:0]       c_seed       = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [ADDR_W-1:0] c_last_addr  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_addr_one   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_err_one    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]        c_drain_last = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t              r_state, w_state;
    logic [15:0]         r_lfsr, w_lfsr;
    logic [15:0]         r_exp, w_exp;
    logic [1:0]          r_drain_cnt, w_drain_cnt;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_pass, w_pass;
    logic [ADDR_W:0]     r_err_cnt, w_err_cnt;
    logic [ADDR_W-1:0]   r_first_err_addr, w_first_err_addr;
    logic                r_ena, w_ena;
    logic                r_wea, w_wea;
    logic [ADDR_W-1:0]   r_addra, w_addra;
    logic [15:0]         r_dina, w_dina;
    logic                w_issue;
    logic                w_mismatch;

    // Expected word and address travel alongside the RAM read latency
    logic                r_pipe_vld  [RD_LAT];
    logic [15:0]         r_pipe_exp  [RD_LAT];
    logic [ADDR_W-1:0]   r_pipe_addr [RD_LAT];

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_lfsr           <= c_seed;
            r_exp            <= '0;
            r_drain_cnt      <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_ena            <= 1'b0;
            r_wea            <= 1'b0;
            r_addra          <= '0;
            r_dina           <= '0;
        end else begin
            r_state          <= w_state;
            r_lfsr           <= w_lfsr;
            r_exp            <= w_exp;
            r_drain_cnt      <= w_drain_cnt;
            r_busy           <= w_busy;
            r_done           <= w_done;
            r_pass           <= w_pass;
            r_err_cnt        <= w_err_cnt;
            r_first_err_addr <= w_first_err_addr;
            r_ena            <= w_ena;
            r_wea            <= w_wea;
            r_addra          <= w_addra;
            r_dina           <= w_dina;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_exp[i]  <= '0;
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= w_issue;
            r_pipe_exp[0]  <= r_exp;
            r_pipe_addr[0] <= r_addra;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_exp[i]  <= r_pipe_exp[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    always_comb begin
        w_state          = r_state;
        w_lfsr           = r_lfsr;
        w_exp            = r_exp;
        w_drain_cnt      = r_drain_cnt;
        w_busy           = r_busy;
        w_done           = 1'b0;
        w_pass           = r_pass;
        w_err_cnt        = r_err_cnt;
        w_first_err_addr = r_first_err_addr;
        w_ena            = r_ena;
        w_wea            = r_wea;
        w_addra          = r_addra;
        w_dina           = r_dina;
        w_issue          = 1'b0;
        w_mismatch       = r_pipe_vld[RD_LAT-1] && (i_douta != r_pipe_exp[RD_LAT-1]);

        if (w_mismatch) begin
            w_err_cnt = r_err_cnt + c_err_one;
            if (r_err_cnt == '0) begin
                w_first_err_addr = r_pipe_addr[RD_LAT-1];
            end
        end

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state          = S_WRITE;
                    w_busy           = 1'b1;
                    w_ena            = 1'b1;
                    w_wea            = 1'b1;
                    w_addra          = '0;
                    w_dina           = c_seed;
                    w_lfsr           = lfsr_step(c_seed);
                    w_err_cnt        = '0;
                    w_first_err_addr = '0;
                    w_pass           = 1'b0;
                end
            end
            S_WRITE: begin
                if (r_addra == c_last_addr) begin
                    w_state = S_GAP;
                    w_ena   = 1'b0;
                    w_wea   = 1'b0;
                    w_addra = '0;
                    w_dina  = '0;
                    w_lfsr  = c_seed;
                end else begin
                    w_addra = r_addra + c_addr_one;
                    w_dina  = r_lfsr;
                    w_lfsr  = lfsr_step(r_lfsr);
                end
            end
            S_GAP: begin
                w_state = S_READ;
                w_ena   = 1'b1;
                w_addra = '0;
                w_exp   = c_seed;
                w_lfsr  = lfsr_step(c_seed);
            end
            S_READ: begin
                w_issue = 1'b1;
                if (r_addra == c_last_addr) begin
                    w_state     = S_DRAIN;
                    w_ena       = 1'b0;
                    w_addra     = '0;
                    w_drain_cnt = '0;
                end else begin
                    w_addra = r_addra + c_addr_one;
                    w_exp   = r_lfsr;
                    w_lfsr  = lfsr_step(r_lfsr);
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_drain_last) begin
                    // Final compare lands on this edge, so judge the updated count
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_err_cnt == '0);
                end else begin
                    w_drain_cnt = r_drain_cnt + 2'd1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_cnt        = r_err_cnt;
    assign o_first_err_addr = r_first_err_addr;
    assign o_ena            = r_ena;
    assign o_wea            = r_wea;
    assign o_addra          = r_addra;
    assign o_dina           = r_dina;

endmodule
`default_nettype wire

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Self-checking write/readback sequencer that drives port A of the on-chip single-port RAM (BRAM, 16-bit data, 2^ADDR_W words). On a start pulse it fills every address with a pseudo-random sequence, reads every address back, compares the returned data against the regenerated sequence, and reports pass/fail, the error count and the first failing address. It sits directly upstream of the RAM, owning its enable, write-enable, address and data-in, and consumes its data-out.

## Interface
- ADDR_W, 8, RAM address width; depth N = 2^ADDR_W.
- RD_LAT, 1, RAM read latency in cycles (1 or 2); must match the RAM core configuration.
- SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'h0001.

- i_sys_clk  in  1  sole clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  one-cycle start request; ignored unless idle.
- o_busy  out  1  high from the cycle after start is accepted until o_done.
- o_done  out  1  one-cycle pulse at end of test.
- o_pass  out  1  valid from o_done until the next accepted start; 1 = zero mismatches.
- o_err_cnt  out  ADDR_W+1  mismatching words in the last run (max N, no saturation needed).
- o_first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- o_ena  out  1  RAM port enable.
- o_wea  out  1  RAM write enable.
- o_addra  out  ADDR_W  RAM address.
- o_dina  out  16  RAM write data.
- i_douta  in  16  RAM read data.

## Operation
- Data pattern: 16-bit Fibonacci LFSR, next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. Word for address i is the LFSR state after i advances from SEED.
- States: IDLE -> WRITE -> GAP -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: RAM outputs all 0. i_start=1 -> WRITE; LFSR loaded with SEED, o_err_cnt, o_first_err_addr, o_pass cleared.
- WRITE: o_ena=1, o_wea=1, o_addra counts 0..N-1, o_dina = LFSR, LFSR advances each cycle. After address N-1 -> GAP.
- GAP: one cycle, o_ena=0, o_wea=0, o_addra=0, o_dina=0; LFSR reloaded with SEED.
- READ: o_ena=1, o_wea=0, o_dina=0, o_addra counts 0..N-1. Expected word and address are delayed by an RD_LAT-deep pipeline with a valid bit; LFSR advances each read. After address N-1 -> DRAIN.
- DRAIN: RD_LAT cycles, RAM outputs 0, pipeline empties.
- Compare: whenever the pipeline valid bit is high, i_douta != expected -> o_err_cnt increments; if it was 0, o_first_err_addr captures the delayed address.
- DONE: one cycle; o_done=1, o_pass = (o_err_cnt==0) registered and held; -> IDLE.
- i_start while busy: ignored, no restart, no state change.
- Address counter wraps only by state exit; no address beyond N-1 is ever driven.

## Timing
- All outputs registered. Reset values: every output 0; state IDLE; LFSR = SEED.
- Start sampled on edge k; define cycle 1 as the cycle after edge k.
- Cycles 1..N: writes, addr 0..N-1. Cycle N+1: gap. Cycles N+2..2N+1: reads addr 0..N-1.
- Read data for address i sampled on i_douta in cycle N+2+i+RD_LAT; last compare in cycle 2N+1+RD_LAT.
- o_done high in cycle 2N+2+RD_LAT; o_busy high in cycles 1..2N+1+RD_LAT, low with o_done.
- Reset mid-run: on the edge where i_rst=1, all outputs return to 0 and state to IDLE (o_ena drops that edge); partial results discarded.
- i_start and i_rst high together: reset wins.
- New start accepted in the cycle after o_done (back-to-back runs allowed).

## Test plan
- Clean run, ADDR_W=8, RD_LAT=1, SEED=16'hACE1, ideal RAM model: write cycle 1 drives addr 0 data 16'hACE1, cycle 2 addr 1 data 16'h59C3; o_done in cycle 515, o_pass=1, o_err_cnt=0, o_first_err_addr=0.
- RD_LAT=2 with matching RAM: o_done in cycle 516, o_pass=1; RD_LAT=2 bench against latency-1 RAM -> o_pass=0, o_err_cnt > 0.
- Fault injection: RAM model flips bit 0 of read data at addresses 5 and 200 -> o_err_cnt=2, o_first_err_addr=5, o_pass=0.
- Stuck-at-zero RAM (i_douta=0 always) -> o_err_cnt=256, o_first_err_addr=0, o_pass=0.
- i_start pulsed at cycle 100 of a run -> ignored, o_done still at cycle 515, single o_done pulse.
- i_rst asserted during READ (cycle 300) -> next cycle all outputs 0, o_busy=0, no o_done; a fresh start then completes with o_pass=1.
